// File: rtl/restoring_divider_seq.sv
// Sequential restoring divider for unsigned N-bit operands.
// One shift-subtract-restore step per clock over the A:Q register pair,
// with a start/busy/done handshake and divide-by-zero short-circuit.
module restoring_divider_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N:0]    a_q, a_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  m_q, m_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;

    // Shifted partial remainder carries one spare top bit (always zero since
    // A < M), so the borrow of the trial subtraction lands in bit N+1.
    logic [N+1:0]  s_ext;
    logic [N+1:0]  diff;
    logic          ge;
    logic [N:0]    a_it;
    logic [N-1:0]  q_it;
    logic          accept;

    // One iteration of shift, trial subtract and restore.
    always_comb begin
        s_ext = {a_q, q_q[N-1]};
        diff  = s_ext - {2'b00, m_q};
        ge    = ~diff[N+1];
        if (ge) begin
            a_it = diff[N:0];
            q_it = {q_q[N-2:0], 1'b1};
        end else begin
            a_it = s_ext[N:0];
            q_it = {q_q[N-2:0], 1'b0};
        end
    end

    // Control FSM and next-state selection for the datapath registers.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        count_d = count_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        accept  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (divisor == '0) begin
                        // No iterations: report saturated quotient at once.
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        a_d     = '0;
                        q_d     = dividend;
                        m_d     = divisor;
                        count_d = CW'(N);
                        dbz_d   = 1'b0;
                    end
                end
            end
            S_RUN: begin
                a_d     = a_it;
                q_d     = q_it;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    // Last step: publish the results as DONE is entered.
                    state_d = S_DONE;
                    quot_d  = q_it;
                    rem_d   = a_it[N-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            count_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            count_q <= count_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);

endmodule
